// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the shifter sequencer.
//   SEL_* constants   : shifter function select encodings.
//   state_t           : sequencer FSM states.
//   shift_op_t        : one latched shifter operation.
//   ref_shift()       : reference result of a legalised operation, used by
//                       the sequencer's assertions.
package shifter_pkg;

    localparam logic [1:0] SEL_LEFT      = 2'd0;
    localparam logic [1:0] SEL_RIGHT     = 2'd1;
    localparam logic [1:0] SEL_SIGNEXT8  = 2'd2;
    localparam logic [1:0] SEL_SIGNEXT16 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] in;
        logic [4:0]  shft;
        logic [1:0]  sel;
        logic        arith;
    } shift_op_t;

    function automatic logic [31:0] ref_shift(input shift_op_t op);
        logic [31:0] r;
        case (op.sel)
            SEL_LEFT:     r = op.in << op.shft;
            SEL_RIGHT:    r = op.arith ? 32'($signed(op.in) >>> op.shft) : (op.in >> op.shft);
            SEL_SIGNEXT8: r = {{24{op.in[7]}}, op.in[7:0]};
            default:      r = {{16{op.in[15]}}, op.in[15:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shifter_ctrl_arb.sv
// rr_arbiter2: two-way arbiter with a round-robin pointer.
//   clk, rst    : clock, synchronous active-high reset.
//   request     : per-requester request.
//   fixed_prio  : 1 = requester 0 always wins; pointer is ignored.
//   advance     : a grant was taken this cycle; update the pointer.
//   grant       : one-hot grant, or 0 when nothing is requested.
// The pointer (last_q) holds the requester granted most recently; it resets
// to 1 so requester 0 wins the first contested arbitration.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] request,
    input  logic       fixed_prio,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        if (request == 2'b11 && !fixed_prio) begin
            // Contested: the requester not granted last time wins.
            grant = last_q ? 2'b01 : 2'b10;
        end else if (request[0]) begin
            grant = 2'b01;
        end else if (request[1]) begin
            grant = 2'b10;
        end

        last_d = last_q;
        if (advance) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/shifter_ctrl.sv
// shifter_ctrl: shares one external combinational 32-bit shifter between two
// requesters. One operation is in flight at a time: accept (IDLE), drive the
// shifter from registers and capture its output (ISSUE), return the result
// to the owner (RESP).
//   CLK, N_RST           : clock, synchronous active-high reset.
//   REQ_VALID/REQ_READY  : per-requester operation handshake.
//   REQ_IN/SHFT/SEL/ARITH: per-requester operation fields.
//   RSP_VALID/RSP_READY  : per-requester result handshake.
//   RSP_OUT              : shared result bus, valid for the RSP_VALID bit set.
//   SH_IN/SHFT/SEL/ARITH : to the shifter, always from the latched operation.
//   SH_OUT               : from the shifter.
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both high on the same bit. REQ_READY is the arbiter grant in IDLE only and
// never depends on RSP_READY. RSP_VALID/RSP_OUT hold until the owner's
// RSP_READY; the non-owner's RSP_READY is ignored.
module shifter_ctrl
    import shifter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             CLK,
    input  logic             N_RST,
    input  logic [1:0]       REQ_VALID,
    output logic [1:0]       REQ_READY,
    input  logic [1:0][31:0] REQ_IN,
    input  logic [1:0][4:0]  REQ_SHFT,
    input  logic [1:0][1:0]  REQ_SEL,
    input  logic [1:0]       REQ_ARITH,
    output logic [1:0]       RSP_VALID,
    input  logic [1:0]       RSP_READY,
    output logic [31:0]      RSP_OUT,
    output logic [31:0]      SH_IN,
    output logic [4:0]       SH_SHFT,
    output logic [1:0]       SH_SEL,
    output logic             SH_ARITH,
    input  logic [31:0]      SH_OUT
);

    state_t      state_q, state_d;
    shift_op_t   op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        owner_q, owner_d;

    logic [1:0]  grant;
    logic        handshake;
    logic        win;
    shift_op_t   req_op;

    rr_arbiter2 u_arb (
        .clk        (CLK),
        .rst        (N_RST),
        .request    (REQ_VALID),
        .fixed_prio (FIXED_PRIO),
        .advance    (handshake),
        .grant      (grant)
    );

    always_comb begin
        REQ_READY = (state_q == IDLE && !N_RST) ? grant : 2'b00;
    end

    assign handshake = |(REQ_VALID & REQ_READY);
    assign win       = REQ_READY[1];

    // Legalise the winner's fields on the way into the operand register:
    // ARITH only means something for right shifts, and sign extension ignores
    // the shift amount.
    always_comb begin
        req_op.in    = REQ_IN[win];
        req_op.sel   = REQ_SEL[win];
        req_op.shft  = (REQ_SEL[win] == SEL_SIGNEXT8 || REQ_SEL[win] == SEL_SIGNEXT16)
                       ? 5'd0 : REQ_SHFT[win];
        req_op.arith = REQ_ARITH[win] && (REQ_SEL[win] == SEL_RIGHT);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        owner_d  = owner_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    op_d    = req_op;
                    owner_d = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                result_d = SH_OUT;
                state_d  = RESP;
            end
            RESP: begin
                if (RSP_READY[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (N_RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            owner_q  <= owner_d;
        end
    end

    assign SH_IN     = op_q.in;
    assign SH_SHFT   = op_q.shft;
    assign SH_SEL    = op_q.sel;
    assign SH_ARITH  = op_q.arith;
    assign RSP_OUT   = result_q;
    assign RSP_VALID = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    a_req_ready_onehot0 : assert property (@(posedge CLK) $onehot0(REQ_READY));
    a_rsp_valid_onehot0 : assert property (@(posedge CLK) $onehot0(RSP_VALID));
    a_arith_only_right  : assert property (@(posedge CLK) SH_ARITH |-> (SH_SEL == SEL_RIGHT));
    a_result_matches    : assert property (@(posedge CLK) disable iff (N_RST)
                                           (state_q == RESP) |-> (RSP_OUT == ref_shift(op_q)));

endmodule

// File: tb/tb_shifter_ctrl.sv
module tb_shifter_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             n_rst;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_in;
    logic [1:0][4:0]  req_shft;
    logic [1:0][1:0]  req_sel;
    logic [1:0]       req_arith;
    logic [1:0]       rsp_ready;

    // round-robin instance
    logic [1:0]  req_ready0, rsp_valid0;
    logic [31:0] rsp_out0, sh_in0, sh_out0;
    logic [4:0]  sh_shft0;
    logic [1:0]  sh_sel0;
    logic        sh_arith0;

    // fixed-priority instance, same stimulus
    logic [1:0]  req_ready1, rsp_valid1;
    logic [31:0] rsp_out1, sh_in1, sh_out1;
    logic [4:0]  sh_shft1;
    logic [1:0]  sh_sel1;
    logic        sh_arith1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Operation as described for the shifter: shift, or sign-extend a byte/half.
    function automatic logic [31:0] shift_model(input logic [31:0] x, input logic [4:0] s,
                                                input logic [1:0] sel, input logic ar);
        logic [63:0] wide;
        case (sel)
            2'd0: return x << s;
            2'd1: begin
                wide = {(ar && x[31]) ? 32'hFFFF_FFFF : 32'h0, x};
                return wide[31:0] >> 0 == 0 ? 32'(wide >> s) : 32'(wide >> s);
            end
            2'd2: return x[7]  ? (32'hFFFF_FF00 | {24'h0, x[7:0]})  : {24'h0, x[7:0]};
            default: return x[15] ? (32'hFFFF_0000 | {16'h0, x[15:0]}) : {16'h0, x[15:0]};
        endcase
    endfunction

    // external shifters
    assign sh_out0 = shift_model(sh_in0, sh_shft0, sh_sel0, sh_arith0);
    assign sh_out1 = shift_model(sh_in1, sh_shft1, sh_sel1, sh_arith1);

    shifter_ctrl #(.FIXED_PRIO(1'b0)) dut (
        .CLK(clk), .N_RST(n_rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready0),
        .REQ_IN(req_in), .REQ_SHFT(req_shft), .REQ_SEL(req_sel), .REQ_ARITH(req_arith),
        .RSP_VALID(rsp_valid0), .RSP_READY(rsp_ready), .RSP_OUT(rsp_out0),
        .SH_IN(sh_in0), .SH_SHFT(sh_shft0), .SH_SEL(sh_sel0), .SH_ARITH(sh_arith0),
        .SH_OUT(sh_out0)
    );

    shifter_ctrl #(.FIXED_PRIO(1'b1)) dut_fp (
        .CLK(clk), .N_RST(n_rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready1),
        .REQ_IN(req_in), .REQ_SHFT(req_shft), .REQ_SEL(req_sel), .REQ_ARITH(req_arith),
        .RSP_VALID(rsp_valid1), .RSP_READY(rsp_ready), .RSP_OUT(rsp_out1),
        .SH_IN(sh_in1), .SH_SHFT(sh_shft1), .SH_SEL(sh_sel1), .SH_ARITH(sh_arith1),
        .SH_OUT(sh_out1)
    );

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        @(negedge clk);
        n_rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        @(negedge clk);
        checks++;
        if (req_ready0 !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready0); end
        checks++;
        if (rsp_valid0 !== 2'b00 || rsp_out0 !== 32'h0) begin
            errors++; $display("FAIL reset_rsp got valid=%b out=%h want 00/0", rsp_valid0, rsp_out0);
        end
        checks++;
        if ({sh_in0, sh_shft0, sh_sel0, sh_arith0} !== 40'h0) begin
            errors++; $display("FAIL reset_sh got %h/%h/%h/%b want 0", sh_in0, sh_shft0, sh_sel0, sh_arith0);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (req_ready0 !== 2'b01 || req_ready1 !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant got %b/%b want 01/01", req_ready0, req_ready1);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    // One operation from requester r on an otherwise idle block; bp cycles of
    // backpressure (non-owner ready only) before the owner consumes.
    task automatic do_op(input int r, input logic [31:0] x, input logic [4:0] s,
                         input logic [1:0] sel, input logic ar, input int bp,
                         input logic [31:0] exp, input string name);
        logic [1:0] rbit;
        logic [4:0] exp_shft;
        logic       exp_ar;
        rbit     = (r == 0) ? 2'b01 : 2'b10;
        exp_shft = (sel >= 2'd2) ? 5'd0 : s;
        exp_ar   = (sel == 2'd1) ? ar : 1'b0;
        req_valid = rbit; req_in[r] = x; req_shft[r] = s; req_sel[r] = sel; req_arith[r] = ar;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready0 !== rbit) begin errors++; $display("FAIL %s grant got %b want %b", name, req_ready0, rbit); end
        @(negedge clk);                         // ISSUE
        req_valid = 2'b11;
        #1;
        checks++;
        if ({sh_in0, sh_shft0, sh_sel0, sh_arith0} !== {x, exp_shft, sel, exp_ar}) begin
            errors++;
            $display("FAIL %s issue got in=%h shft=%0d sel=%0d ar=%b want in=%h shft=%0d sel=%0d ar=%b",
                     name, sh_in0, sh_shft0, sh_sel0, sh_arith0, x, exp_shft, sel, exp_ar);
        end
        checks++;
        if (req_ready0 !== 2'b00 || rsp_valid0 !== 2'b00) begin
            errors++; $display("FAIL %s issue_hs got ready=%b valid=%b want 00/00", name, req_ready0, rsp_valid0);
        end
        @(negedge clk);                         // RESP, cycle k+2
        checks++;
        if (rsp_valid0 !== rbit || rsp_out0 !== exp || req_ready0 !== 2'b00) begin
            errors++; $display("FAIL %s resp got valid=%b out=%h ready=%b want %b/%h/00",
                               name, rsp_valid0, rsp_out0, req_ready0, rbit, exp);
        end
        rsp_ready = ~rbit;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid0 !== rbit || rsp_out0 !== exp || req_ready0 !== 2'b00) begin
                errors++; $display("FAIL %s hold%0d got valid=%b out=%h ready=%b want %b/%h/00",
                                   name, i, rsp_valid0, rsp_out0, req_ready0, rbit, exp);
            end
        end
        rsp_ready = rbit; req_valid = rbit;
        #1;
        checks++;
        if (req_ready0 !== 2'b00) begin errors++; $display("FAIL %s same_cycle_accept got %b want 00", name, req_ready0); end
        @(negedge clk);                         // back in IDLE
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (rsp_valid0 !== 2'b00 || req_ready0 !== rbit) begin
            errors++; $display("FAIL %s return got valid=%b ready=%b want 00/%b", name, rsp_valid0, req_ready0, rbit);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_left();
        do_op(0, 32'h0000_00F1, 5'd4, 2'd0, 1'b0, 0, 32'h0000_0F10, "left");
    endtask

    task automatic test_arith_right();
        do_op(1, 32'h8000_0000, 5'd31, 2'd1, 1'b1, 0, 32'hFFFF_FFFF, "asr");
        do_op(0, 32'h8000_0000, 5'd4, 2'd1, 1'b0, 0, 32'h0800_0000, "lsr");
    endtask

    task automatic test_legalise();
        do_op(0, 32'h8000_0001, 5'd1, 2'd0, 1'b1, 0, 32'h0000_0002, "legal_arith");
        do_op(0, 32'h0000_0080, 5'd7, 2'd2, 1'b0, 0, 32'hFFFF_FF80, "legal_sext8");
        do_op(1, 32'h1234_8001, 5'd9, 2'd3, 1'b1, 1, 32'hFFFF_8001, "legal_sext16");
    endtask

    task automatic test_backpressure();
        do_op(1, 32'h0F0F_1234, 5'd8, 2'd0, 1'b0, 5, 32'h0F12_3400, "backpressure");
    endtask

    task automatic test_round_robin();
        logic [31:0] x[2];
        logic [4:0]  s[2];
        logic [1:0]  sl[2];
        logic        a[2];
        int          last_m;
        int          w;
        logic [1:0]  wbit;
        reset_dut();
        last_m = 1;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++) begin
                x[r] = $urandom; s[r] = 5'($urandom_range(0, 31));
                sl[r] = 2'($urandom_range(0, 3)); a[r] = 1'($urandom_range(0, 1));
                req_in[r] = x[r]; req_shft[r] = s[r]; req_sel[r] = sl[r]; req_arith[r] = a[r];
            end
            req_valid = 2'b11;
            w = (last_m == 1) ? 0 : 1;          // contested: the other one wins
            wbit = (w == 0) ? 2'b01 : 2'b10;
            last_m = w;
            exp_q.push_back(shift_model(x[w], s[w], sl[w], a[w]));
            #1;
            checks++;
            if (req_ready0 !== wbit || req_ready1 !== 2'b01) begin
                errors++; $display("FAIL rr_grant%0d got %b/%b want %b/01", i, req_ready0, req_ready1, wbit);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid0 !== wbit || rsp_out0 !== exp_q[0]) begin
                errors++; $display("FAIL rr_resp%0d got %b/%h want %b/%h", i, rsp_valid0, rsp_out0, wbit, exp_q[0]);
            end
            void'(exp_q.pop_front());
            checks++;
            if (rsp_valid1 !== 2'b01 || rsp_out1 !== shift_model(x[0], s[0], sl[0], a[0])) begin
                errors++; $display("FAIL fp_resp%0d got %b/%h want 01/%h", i, rsp_valid1, rsp_out1,
                                   shift_model(x[0], s[0], sl[0], a[0]));
            end
            rsp_ready = 2'b11;
            @(negedge clk);
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random();
        int r, bp;
        logic [31:0] x;
        logic [4:0]  s;
        logic [1:0]  sl;
        logic        a;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 1); bp = $urandom_range(0, 2);
            x = $urandom; s = 5'($urandom_range(0, 31));
            sl = 2'($urandom_range(0, 3)); a = 1'($urandom_range(0, 1));
            exp_q.push_back(shift_model(x, s, sl, a));
            do_op(r, x, s, sl, a, bp, exp_q.pop_front(), "random");
        end
    endtask

    task automatic test_mid_reset();
        do_op(0, 32'h1, 5'd1, 2'd0, 1'b0, 0, 32'h2, "pre_reset");   // pointer now at 0
        req_valid = 2'b10; req_in[1] = 32'hDEAD_BEEF; req_shft[1] = 5'd3;
        req_sel[1] = 2'd1; req_arith[1] = 1'b1;
        @(negedge clk);                         // ISSUE
        n_rst = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({req_ready0, rsp_valid0, rsp_out0, sh_in0, sh_shft0, sh_sel0, sh_arith0} !== 76'h0) begin
            errors++; $display("FAIL midrst_outputs got ready=%b valid=%b out=%h sh=%h/%h/%h/%b want 0",
                               req_ready0, rsp_valid0, rsp_out0, sh_in0, sh_shft0, sh_sel0, sh_arith0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid0 !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp%0d got %b want 00", i, rsp_valid0); end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready0 !== 2'b01) begin errors++; $display("FAIL midrst_grant got %b want 01", req_ready0); end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_in = '0; req_shft = '0; req_sel = '0; req_arith = '0;
        test_reset();
        test_left();
        test_arith_right();
        test_legalise();
        test_backpressure();
        test_round_robin();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
